mul_div_iter: RTL and testbench

Parametrised, multi-cycle integer multiply/divide unit for the EXE stage. It covers MUL.W, MULH.W and MULH.WU, and adds DIV.W, MOD.W, DIV.WU and MOD.WU. It replaces the single-cycle combinational multiplier path with a radix-2 iterative datapath behind valid/ready handshakes. The pipeline stalls EXE on `in_ready`/`out_valid` and kills in-flight work with `flush` on exception or branch redirect.

---
 rtl/mul_div_iter.sv | 135 +++++++++++++
 tb/tb_mul_div_iter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_iter.sv
// Radix-2 iterative multiply/divide unit: shift-add multiply, restoring divide,
// sign handled by magnitude operands plus a final correction folded into the result write.
module mul_div_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             busy
);
    // state | meaning
    // IDLE  | waiting for a request, in_ready high
    // CALC  | one multiply/divide iteration per cycle, WIDTH iterations
    // DONE  | result held on out_result until out_ready or flush
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [2:0]       OP_MUL = 3'd0;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               neg_res_q, neg_rem_q;
    logic [WIDTH-1:0]   result_q;

    logic [2:0]         op_in;
    logic               signed_in, neg1_in, neg2_in, div_zero_in, accept, last_iter;
    logic [WIDTH-1:0]   mag1_in, mag2_in;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, acc_next, prod_fin;
    logic [WIDTH-1:0]   quo, rem, quo_fin, rem_fin, result_fin;

    // Code 3 is reserved and folded onto MUL; after that, op[1]==0 marks the signed ops.
    always_comb begin
        op_in       = (in_op == 3'd3) ? OP_MUL : in_op;
        signed_in   = ~op_in[1];
        neg1_in     = signed_in & in_src1[WIDTH-1];
        neg2_in     = signed_in & in_src2[WIDTH-1];
        mag1_in     = neg1_in ? -in_src1 : in_src1;
        mag2_in     = neg2_in ? -in_src2 : in_src2;
        div_zero_in = op_in[2] & (in_src2 == '0);
        accept      = (state_q == IDLE) & in_valid & ~flush;
        last_iter   = (state_q == CALC) & (cnt_q == LAST);
    end

    // acc_q holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        div_next  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                           : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        acc_next  = op_q[2] ? div_next : mul_next;

        prod_fin  = neg_res_q ? -mul_next : mul_next;
        quo       = div_next[WIDTH-1:0];
        rem       = div_next[2*WIDTH-1:WIDTH];
        quo_fin   = neg_res_q ? -quo : quo;
        rem_fin   = neg_rem_q ? -rem : rem;

        if (op_q[2])
            result_fin = op_q[0] ? rem_fin : quo_fin;
        else if (op_q[1:0] == 2'd0)
            result_fin = prod_fin[WIDTH-1:0];
        else
            result_fin = prod_fin[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = div_zero_in ? DONE : CALC;
            CALC:    if (flush) state_d = IDLE;
                     else if (last_iter) state_d = DONE;
            DONE:    if (flush || out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q     <= '0;
            op_q      <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else if (accept) begin
            cnt_q     <= '0;
            op_q      <= op_in;
            opnd_q    <= mag2_in;
            acc_q     <= {{WIDTH{1'b0}}, mag1_in};
            neg_res_q <= neg1_in ^ neg2_in;
            neg_rem_q <= neg1_in;
            // divide by zero: remainder is the raw dividend, quotient all ones
            if (div_zero_in)
                result_q <= op_in[0] ? in_src1 : '1;
        end else if (state_q == CALC && !flush) begin
            acc_q <= acc_next;
            if (cnt_q != LAST)
                cnt_q <= cnt_q + 1'b1;
            if (last_iter)
                result_q <= result_fin;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = result_q;

endmodule

// File: tb/tb_mul_div_iter.sv
// Scoreboard bench for mul_div_iter: a 32-bit and a 16-bit instance, directed vectors,
// expected results queued at issue and popped by per-instance monitors on each handshake.
module tb_mul_div_iter;
    logic        clk = 1'b0;
    logic        resetn;
    logic        flush     [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [2:0]  in_op     [2];
    logic [31:0] in_src1   [2];
    logic [31:0] in_src2   [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_result[2];
    logic        busy      [2];
    logic [15:0] res16;

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    int checks = 0;
    int errors = 0;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHU = 3'd2, RSV = 3'd3,
                           DIV = 3'd4, MOD = 3'd5, DIVU = 3'd6, MODU = 3'd7;

    always #5 clk = ~clk;

    mul_div_iter #(.WIDTH(32)) dut32 (
        .clk(clk), .resetn(resetn), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_op(in_op[0]),
        .in_src1(in_src1[0]), .in_src2(in_src2[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_result(out_result[0]), .busy(busy[0])
    );

    mul_div_iter #(.WIDTH(16)) dut16 (
        .clk(clk), .resetn(resetn), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_op(in_op[1]),
        .in_src1(in_src1[1][15:0]), .in_src2(in_src2[1][15:0]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_result(res16), .busy(busy[1])
    );
    assign out_result[1] = {16'h0, res16};

    // flush wins over a same-cycle handshake, so such a result is never popped
    always @(negedge clk) begin
        if (resetn && out_valid[0] && out_ready[0] && !flush[0]) begin
            checks++;
            if (exp_q0.size() == 0) begin
                errors++;
                $display("FAIL result_dut32: unexpected result %h with empty scoreboard", out_result[0]);
            end else begin
                logic [31:0] e;
                e = exp_q0.pop_front();
                if (out_result[0] !== e) begin
                    errors++;
                    $display("FAIL result_dut32: got %h expected %h", out_result[0], e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && out_valid[1] && out_ready[1] && !flush[1]) begin
            checks++;
            if (exp_q1.size() == 0) begin
                errors++;
                $display("FAIL result_dut16: unexpected result %h with empty scoreboard", out_result[1]);
            end else begin
                logic [31:0] e;
                e = exp_q1.pop_front();
                if (out_result[1] !== e) begin
                    errors++;
                    $display("FAIL result_dut16: got %h expected %h", out_result[1], e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives a request for one cycle; returns #1 after the accept edge.
    task automatic start(input int d, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        chk($sformatf("in_ready_before_issue_d%0d", d), {31'b0, in_ready[d]}, 32'd1);
        in_valid[d] = 1'b1;
        in_op[d]    = op;
        in_src1[d]  = a;
        in_src2[d]  = b;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
    endtask

    // Edges after the accept edge until out_valid is seen.
    task automatic wait_valid(input int d, output int lat);
        lat = 0;
        while (!out_valid[d] && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (!in_ready[d] && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("return_idle_d%0d", d), {31'b0, in_ready[d]}, 32'd1);
    endtask

    task automatic run(input int d, input string name, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat);
        int lat;
        if (d == 0) exp_q0.push_back(exp);
        else        exp_q1.push_back(exp);
        start(d, op, a, b);
        wait_valid(d, lat);
        chk({"latency_", name}, lat, exp_lat);
        wait_idle(d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic seen;
        resetn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            flush[d] = 1'b0; in_valid[d] = 1'b0; in_op[d] = 3'd0;
            in_src1[d] = '0; in_src2[d] = '0; out_ready[d] = 1'b1;
        end
        // request held during reset must be ignored
        in_valid[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", {31'b0, in_ready[0]}, 32'd1);
        chk("reset_out_valid", {31'b0, out_valid[0]}, 32'd0);
        chk("reset_busy", {31'b0, busy[0]}, 32'd0);
        chk("reset_out_result", out_result[0], 32'd0);
        in_valid[0] = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        run(0, "mul",   MUL,   32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32);
        run(0, "mulh",  MULH,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32);
        run(0, "mulhu", MULHU, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 32);
        run(0, "rsv",   RSV,   32'h0000_0003, 32'h0000_0004, 32'h0000_000C, 32);
        run(0, "div",   DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32);
        run(0, "mod",   MOD,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32);
        run(0, "divu",  DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 32);
        run(0, "modu",  MODU,  32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32);
        run(0, "div0",  DIV,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 0);
        run(0, "mod0",  MOD,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 0);
        run(0, "divu0", DIVU,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0);
        run(0, "ovf_div", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32);
        run(0, "ovf_mod", MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32);
        run(0, "mod_neg_div", MOD, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32);

        // backpressure: five cycles of out_ready low in DONE
        out_ready[0] = 1'b0;
        exp_q0.push_back(32'h0000_0E38);
        start(0, MUL, 32'h0000_0038, 32'h0000_0041);
        wait_valid(0, lat);
        chk("latency_bp", lat, 32);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", {31'b0, out_valid[0]}, 32'd1);
            chk("bp_out_result", out_result[0], 32'h0000_0E38);
            chk("bp_in_ready", {31'b0, in_ready[0]}, 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", {31'b0, in_ready[0]}, 32'd1);
        chk("bp_release_out_valid", {31'b0, out_valid[0]}, 32'd0);
        run(0, "after_bp", DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 32);

        // flush mid-CALC: no result may appear
        start(0, MUL, 32'h0000_0005, 32'h0000_0006);
        repeat (10) @(posedge clk);
        #1;
        flush[0] = 1'b1;
        @(posedge clk);
        #1;
        flush[0] = 1'b0;
        chk("flush_busy", {31'b0, busy[0]}, 32'd0);
        chk("flush_out_valid", {31'b0, out_valid[0]}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            seen |= out_valid[0];
        end
        chk("flush_no_valid_pulse", {31'b0, seen}, 32'd0);
        run(0, "mul_after_flush", MUL, 32'h0000_0003, 32'h0000_0004, 32'h0000_000C, 32);

        // flush coincident with a request in IDLE
        @(negedge clk);
        in_valid[0] = 1'b1; flush[0] = 1'b1;
        in_op[0] = MUL; in_src1[0] = 32'd9; in_src2[0] = 32'd9;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0; flush[0] = 1'b0;
        chk("flush_idle_not_accepted", {31'b0, busy[0]}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_idle_no_valid", {31'b0, out_valid[0]}, 32'd0);

        // 16-bit instance
        run(1, "mul16",   MUL,   32'h0007, 32'hFFFD, 32'h0000_FFEB, 16);
        run(1, "mulh16",  MULH,  32'h0007, 32'hFFFD, 32'h0000_FFFF, 16);
        run(1, "mulhu16", MULHU, 32'h0007, 32'hFFFD, 32'h0000_0006, 16);
        run(1, "div16",   DIV,   32'hFFF9, 32'h0002, 32'h0000_FFFD, 16);
        run(1, "mod16",   MOD,   32'hFFF9, 32'h0002, 32'h0000_FFFF, 16);
        run(1, "divu16",  DIVU,  32'hFFF9, 32'h0002, 32'h0000_7FFC, 16);
        run(1, "modu16",  MODU,  32'hFFF9, 32'h0002, 32'h0000_0001, 16);
        run(1, "div0_16", DIV,   32'h0005, 32'h0000, 32'h0000_FFFF, 0);
        run(1, "ovf16",   DIV,   32'h8000, 32'hFFFF, 32'h0000_8000, 16);
        run(1, "ovfm16",  MOD,   32'h8000, 32'hFFFF, 32'h0000_0000, 16);

        // reset mid-CALC: outputs return to reset values without a clock edge
        start(0, MUL, 32'h0000_0009, 32'h0000_0009);
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("rst_mid_out_valid", {31'b0, out_valid[0]}, 32'd0);
        chk("rst_mid_busy", {31'b0, busy[0]}, 32'd0);
        chk("rst_mid_in_ready", {31'b0, in_ready[0]}, 32'd1);
        chk("rst_mid_out_result", out_result[0], 32'd0);
        chk("rst_mid_out_result16", out_result[1], 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        run(0, "mul_after_reset", MUL, 32'h0000_0003, 32'h0000_0004, 32'h0000_000C, 32);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty_dut32", exp_q0.size(), 32'd0);
        chk("scoreboard_empty_dut16", exp_q1.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
